// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants, occupancy encoding and issue threshold
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2,
    OCC_FULL  = 2'd3
  } occ_t;

  // A read may be issued only if the buffer can absorb it together with the word in flight.
  function automatic logic issue_ok(input occ_t occ, input logic pend);
    return (3'(occ) + 3'(pend)) < 3'(BUF_DEPTH);
  endfunction

  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    return (idx == 2'(BUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus valid/ready stream bundle
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             rinc;
  logic             rempty;
  logic [WIDTH-1:0] rdata;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output rinc, m_valid, m_data,
    input  rempty, rdata, m_ready
  );

  modport slave (
    input  rinc, m_valid, m_data,
    output rempty, rdata, m_ready
  );
endinterface

// File: rtl/fifo_rd_stream_skid.sv
// rtl/fifo_rd_stream_skid.sv - 3-entry circular buffer with occupancy state
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output occ_t             o_count,
  output logic [WIDTH-1:0] o_head_data
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [1:0]       r_head;
  logic [1:0]       r_tail;
  occ_t             r_state;
  occ_t             w_state_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= OCC_EMPTY;
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_state <= OCC_EMPTY;
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= idx_next(r_tail);
      end
      if (i_pop) r_head <= idx_next(r_head);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case ({i_push, i_pop})
      2'b10: begin
        case (r_state)
          OCC_EMPTY: w_state_nxt = OCC_ONE;
          OCC_ONE:   w_state_nxt = OCC_TWO;
          default:   w_state_nxt = OCC_FULL;
        endcase
      end
      2'b01: begin
        case (r_state)
          OCC_FULL: w_state_nxt = OCC_TWO;
          OCC_TWO:  w_state_nxt = OCC_ONE;
          default:  w_state_nxt = OCC_EMPTY;
        endcase
      end
      default: w_state_nxt = r_state;
    endcase
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && !i_clear && r_state == OCC_FULL));

  assign o_count     = r_state;
  assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - async FIFO read-side consumer presenting a valid/ready stream
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_rclk,
  input  logic                 i_rrst,
  input  logic                 i_flush,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] o_rd_cnt
);

  logic                 r_rd_pend;
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  occ_t                 w_count;
  logic [WIDTH-1:0]     w_head;
  logic                 w_rinc;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  // Only rempty is a live input here; m_ready never reaches rinc.
  assign w_rinc   = !i_rrst && !i_flush && !bus.rempty && issue_ok(w_count, r_rd_pend);
  assign w_accept = w_rinc && !bus.rempty;
  assign w_pop    = (w_count != OCC_EMPTY) && bus.m_ready && !i_flush;
  assign w_push   = r_rd_pend && !i_flush;

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_rd_pend <= 1'b0;
      r_rd_cnt  <= '0;
    end else if (i_flush) begin
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_accept;
      if (w_pop) r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
    end
  end

  rd_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .i_clk       (i_rclk),
    .i_rst       (i_rrst),
    .i_clear     (i_flush),
    .i_push      (w_push),
    .i_push_data (bus.rdata),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_data (w_head)
  );

  assign bus.rinc    = w_rinc;
  assign bus.m_valid = (w_count != OCC_EMPTY);
  assign bus.m_data  = w_head;
  assign o_rd_cnt    = r_rd_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized and directed bench against a queue-based model
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rrst;
  logic        flush;
  logic [15:0] rd_cnt;
  logic [3:0]  rd_cnt4;

  fifo_rd_stream_if #(.WIDTH(8)) bus ();
  fifo_rd_stream_if #(.WIDTH(8)) bus4 ();

  assign bus4.rempty  = bus.rempty;
  assign bus4.rdata   = bus.rdata;
  assign bus4.m_ready = bus.m_ready;

  fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .i_rclk(clk), .i_rrst(rrst), .i_flush(flush), .bus(bus), .o_rd_cnt(rd_cnt)
  );

  fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .i_rclk(clk), .i_rrst(rrst), .i_flush(flush), .bus(bus4), .o_rd_cnt(rd_cnt4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: FIFO contents, stream buffer contents, word in flight, pop count
  logic [7:0]  fifo_q[$];
  logic [7:0]  bq[$];
  logic        pend;
  logic [7:0]  pend_word;
  logic [15:0] cnt;

  logic d_rst, d_flush, d_ready, d_stall;
  logic obs_rinc, obs_valid, obs_accept;
  logic [7:0]  obs_data;
  logic [15:0] obs_cnt;
  logic [3:0]  obs_cnt4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [7:0] w;
    logic exp_rinc, exp_valid, pop, acc;
    bus.rempty  = (fifo_q.size() == 0) || d_stall;
    bus.m_ready = d_ready;
    flush       = d_flush;
    rrst        = d_rst;
    @(negedge clk);
    obs_rinc  = bus.rinc;
    obs_valid = bus.m_valid;
    obs_data  = bus.m_data;
    obs_cnt   = rd_cnt;
    obs_cnt4  = rd_cnt4;
    exp_rinc  = !d_rst && !d_flush && !bus.rempty && ((bq.size() + int'(pend)) < 3);
    exp_valid = (bq.size() != 0);
    check("rinc", 32'(obs_rinc), 32'(exp_rinc));
    check("m_valid", 32'(obs_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(obs_data), 32'(bq[0]));
    check("rd_cnt", 32'(obs_cnt), 32'(cnt));
    check("rd_cnt4", 32'(obs_cnt4), 32'(cnt[3:0]));
    acc = obs_rinc && !bus.rempty;
    obs_accept = acc;
    pop = exp_valid && d_ready;
    if (d_rst) begin
      bq.delete(); pend = 1'b0; cnt = '0;
    end else if (d_flush) begin
      bq.delete(); pend = 1'b0;
    end else begin
      if (pop) begin
        void'(bq.pop_front());
        cnt = cnt + 16'd1;
      end
      if (pend) begin
        check("no_overflow", 32'(bq.size() >= 3), 32'd0);
        bq.push_back(pend_word);
      end
      pend = acc;
    end
    if (acc) begin
      w = fifo_q.pop_front();
      pend_word = w;
    end else begin
      w = 8'($urandom);
    end
    @(posedge clk);
    #1;
    bus.rdata = w;
  endtask

  task automatic do_reset();
    fifo_q.delete();
    d_rst = 1'b1; d_flush = 1'b0; d_stall = 1'b0;
    step();
    step();
    d_rst = 1'b0;
  endtask

  int first_v, last_v, nvalid, nacc;

  initial begin
    rrst = 1'b1; flush = 1'b0; bus.rempty = 1'b1; bus.m_ready = 1'b0; bus.rdata = '0;
    pend = 1'b0; pend_word = '0; cnt = '0;
    d_rst = 1'b1; d_flush = 1'b0; d_ready = 1'b0; d_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_rinc", 32'(obs_rinc), 32'd0);
      check("idle_valid", 32'(obs_valid), 32'd0);
      check("idle_data", 32'(obs_data), 32'd0);
      check("idle_cnt", 32'(obs_cnt), 32'd0);
    end

    // single word latency
    fifo_q.push_back(8'hA5);
    d_ready = 1'b1;
    step(); check("single_rinc_c0", 32'(obs_rinc), 32'd1);
    step(); check("single_valid_c1", 32'(obs_valid), 32'd0);
    step(); check("single_valid_c2", 32'(obs_valid), 32'd1);
    check("single_data_c2", 32'(obs_data), 32'hA5);
    step(); check("single_cnt", 32'(obs_cnt), 32'd1);

    // streaming throughput
    do_reset();
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
    d_ready = 1'b1; first_v = -1; last_v = -1; nvalid = 0;
    for (int c = 0; c < 22; c++) begin
      step();
      if (obs_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nvalid++;
      end
    end
    check("stream_nvalid", 32'(nvalid), 32'd16);
    check("stream_first", 32'(first_v), 32'd2);
    check("stream_nogap", 32'(last_v - first_v + 1), 32'd16);
    check("stream_cnt", 32'(obs_cnt), 32'd16);

    // backpressure
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h30 + 8'(i));
    d_ready = 1'b0; nacc = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs_accept) nacc++;
      if (obs_valid) check("bp_hold_data", 32'(obs_data), 32'h30);
    end
    check("bp_accepts", 32'(nacc), 32'd3);
    d_ready = 1'b1;
    for (int c = 0; c < 12; c++) step();
    check("bp_total", 32'(obs_cnt), 32'd8);

    // flush at occupancy TWO with a read in flight
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h50 + 8'(i));
    d_ready = 1'b0;
    repeat (3) step();
    d_flush = 1'b1;
    step();
    check("flush_rinc", 32'(obs_rinc), 32'd0);
    check("flush_prevalid", 32'(obs_valid), 32'd1);
    d_flush = 1'b0; d_ready = 1'b1;
    step();
    check("flush_valid_after", 32'(obs_valid), 32'd0);
    check("flush_cnt", 32'(obs_cnt), 32'd0);
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_valid && nvalid == 0) begin
        check("flush_resume", 32'(obs_data), 32'h53);
        nvalid = 1;
      end
    end
    check("flush_resumed", 32'(nvalid), 32'd1);

    // counter wrap on the narrow instance
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom));
    d_ready = 1'b1;
    for (int c = 0; c < 24; c++) step();
    check("wrap_cnt4", 32'(obs_cnt4), 32'd1);
    check("wrap_cnt16", 32'(obs_cnt), 32'd17);

    // reset mid-stream
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom));
    for (int c = 0; c < 6; c++) begin
      d_ready = 1'($urandom);
      step();
    end
    d_rst = 1'b1;
    step();
    check("midrst_rinc", 32'(obs_rinc), 32'd0);
    d_rst = 1'b0; d_stall = 1'b1;
    step();
    check("midrst_valid", 32'(obs_valid), 32'd0);
    check("midrst_data", 32'(obs_data), 32'd0);
    check("midrst_cnt", 32'(obs_cnt), 32'd0);
    d_stall = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 20) fifo_q.push_back(8'($urandom));
      d_ready = ($urandom_range(0, 3) != 0);
      d_stall = ($urandom_range(0, 9) == 0);
      d_flush = ($urandom_range(0, 49) == 0);
      d_rst   = ($urandom_range(0, 299) == 0);
      step();
    end
    d_rst = 1'b0; d_flush = 1'b0; d_stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
